// File: rtl/nor_block_lock_engine_if.sv
// Control handshake and flash strobe/address bundle for the NOR block-lock engine.
// The flash data bus is bidirectional, so it stays a plain inout port on the engine.
interface nor_block_lock_engine_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              START;
    logic [1:0]        MODE;
    logic              VERIFY;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [15:0]       FAIL_IDX;
    logic              CE;
    logic              WE;
    logic              OE;
    logic [ADDR_W-1:0] ADDR;

    modport master (
        output START, MODE, VERIFY,
        input  BUSY, DONE, ERR, FAIL_IDX, CE, WE, OE, ADDR
    );

    modport slave (
        input  START, MODE, VERIFY,
        output BUSY, DONE, ERR, FAIL_IDX, CE, WE, OE, ADDR
    );
endinterface

// File: rtl/nor_block_lock_engine.sv
// Sweeps every block of a boot-block NOR array issuing lock-setup/confirm commands,
// optionally reading back each block's lock status via the read-ID space.
module nor_block_lock_engine #(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned SMALL_BLKS = 4,
    parameter int unsigned SMALL_SIZE = 'h004000,
    parameter int unsigned LARGE_BLKS = 255,
    parameter int unsigned LARGE_SIZE = 'h010000,
    parameter int unsigned T_PWR      = 5,
    parameter int unsigned T_WP       = 3,
    parameter int unsigned T_WPH      = 2,
    parameter int unsigned T_RD       = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    nor_block_lock_engine_if.slave bus,
    inout  wire  [15:0]            DATA
);
    localparam int unsigned N_BLKS = SMALL_BLKS + LARGE_BLKS;
    localparam int unsigned CNT_W  = $clog2(T_PWR + T_WP + T_WPH + T_RD + 2);

    localparam logic [CNT_W-1:0]  PWR_LAST  = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0]  WR_LO     = CNT_W'(T_WP);
    localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(T_WP + T_WPH - 1);
    localparam logic [CNT_W-1:0]  RD_LO     = CNT_W'(T_RD);
    localparam logic [CNT_W-1:0]  RD_SMP    = CNT_W'(T_RD - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_BLKS - 1);
    localparam logic [ADDR_W-1:0] SMALL_END = ADDR_W'(SMALL_BLKS);
    localparam logic [ADDR_W-1:0] S_STRIDE  = ADDR_W'(SMALL_SIZE);
    localparam logic [ADDR_W-1:0] L_STRIDE  = ADDR_W'(LARGE_SIZE);

    typedef enum logic [3:0] {
        S_PWAIT, S_IDLE, S_SETUP, S_CONFIRM, S_RDID, S_READ, S_RESTORE, S_NEXT, S_FIN
    } state_t;

    // Everything that leaves the block is registered so the flash strobes are glitch-free.
    typedef struct packed {
        logic              ce;
        logic              we;
        logic              oe;
        logic [ADDR_W-1:0] addr;
        logic              dq_oe;
        logic [15:0]       dq;
        logic              busy;
        logic              done;
    } pins_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [1:0]        mode_q, mode_n;
    logic              verify_q, verify_n;
    logic              err_q;
    logic [15:0]       fail_q;
    logic              start_acc;
    logic              smp_fail;
    pins_t             pins_q, pins_n;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_PWAIT;
            cnt      <= '0;
            idx      <= '0;
            base     <= '0;
            mode_q   <= '0;
            verify_q <= 1'b0;
            err_q    <= 1'b0;
            fail_q   <= '0;
            pins_q   <= '{ce: 1'b1, we: 1'b1, oe: 1'b1, addr: '0, dq_oe: 1'b0,
                          dq: '0, busy: 1'b1, done: 1'b0};
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            base     <= base_n;
            mode_q   <= mode_n;
            verify_q <= verify_n;
            pins_q   <= pins_n;
            if (start_acc) begin
                err_q <= 1'b0;
            end else if (smp_fail && !err_q) begin
                err_q  <= 1'b1;
                fail_q <= 16'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        idx_n     = idx;
        base_n    = base;
        mode_n    = mode_q;
        verify_n  = verify_q;
        start_acc = 1'b0;
        smp_fail  = 1'b0;

        unique case (state)
            S_PWAIT: if (cnt == PWR_LAST) begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            S_IDLE: begin
                cnt_n = '0;
                if (bus.START) begin
                    start_acc = 1'b1;
                    state_n   = S_SETUP;
                    idx_n     = '0;
                    base_n    = '0;
                    mode_n    = bus.MODE;
                    verify_n  = bus.VERIFY;
                end
            end
            S_SETUP: if (cnt == WR_LAST) begin
                state_n = S_CONFIRM;
                cnt_n   = '0;
            end
            S_CONFIRM: if (cnt == WR_LAST) begin
                state_n = verify_q ? S_RDID : S_NEXT;
                cnt_n   = '0;
            end
            S_RDID: if (cnt == WR_LAST) begin
                state_n = S_READ;
                cnt_n   = '0;
            end
            S_READ: begin
                if (cnt == RD_SMP) begin
                    case (mode_q)
                        2'b01:   smp_fail = !DATA[0];
                        2'b10:   smp_fail = !(DATA[1] && DATA[0]);
                        default: smp_fail = DATA[0];
                    endcase
                end
                if (cnt == RD_LO) begin
                    state_n = S_RESTORE;
                    cnt_n   = '0;
                end
            end
            S_RESTORE: if (cnt == WR_LAST) begin
                state_n = S_NEXT;
                cnt_n   = '0;
            end
            S_NEXT: begin
                cnt_n = '0;
                if (idx == LAST_IDX) begin
                    state_n = S_FIN;
                end else begin
                    state_n = S_SETUP;
                    idx_n   = idx + 1'b1;
                    base_n  = base + ((idx < SMALL_END) ? S_STRIDE : L_STRIDE);
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_PWAIT;
                cnt_n   = '0;
            end
        endcase

        // Decode the pins for the state being entered; DATA stays driven one cycle past WE rising.
        pins_n = '{ce: 1'b1, we: 1'b1, oe: 1'b1, addr: '0, dq_oe: 1'b0,
                   dq: '0, busy: 1'b1, done: 1'b0};
        unique case (state_n)
            S_IDLE: pins_n.busy = 1'b0;
            S_FIN: begin
                pins_n.busy = 1'b0;
                pins_n.done = 1'b1;
            end
            S_SETUP, S_CONFIRM, S_RDID, S_RESTORE: begin
                pins_n.addr  = base_n;
                pins_n.ce    = !(cnt_n < WR_LO);
                pins_n.we    = !(cnt_n < WR_LO);
                pins_n.dq_oe = (cnt_n <= WR_LO);
                case (state_n)
                    S_SETUP:   pins_n.dq = 16'h0060;
                    S_RDID:    pins_n.dq = 16'h0090;
                    S_RESTORE: pins_n.dq = 16'h00FF;
                    default: begin
                        case (mode_n)
                            2'b01:   pins_n.dq = 16'h0001;
                            2'b10:   pins_n.dq = 16'h002F;
                            default: pins_n.dq = 16'h00D0;
                        endcase
                    end
                endcase
            end
            S_READ: begin
                pins_n.addr = base_n + ADDR_W'(2);
                pins_n.ce   = !(cnt_n < RD_LO);
                pins_n.oe   = !(cnt_n < RD_LO);
            end
            S_NEXT: pins_n.addr = base_n;
            default: ;
        endcase
    end

    assign DATA         = pins_q.dq_oe ? pins_q.dq : 16'hzzzz;
    assign bus.CE       = pins_q.ce;
    assign bus.WE       = pins_q.we;
    assign bus.OE       = pins_q.oe;
    assign bus.ADDR     = pins_q.addr;
    assign bus.BUSY     = pins_q.busy;
    assign bus.DONE     = pins_q.done;
    assign bus.ERR      = err_q;
    assign bus.FAIL_IDX = fail_q;
endmodule

// File: tb/tb_nor_block_lock_engine.sv
// Directed bench: power-up, unlock/lock/lock-down sweeps with and without verify,
// START/MODE noise during a sweep, and reset in the middle of a confirm write.
module tb_nor_block_lock_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    wire  [15:0] DATA;
    int          n_chk = 0;
    int          n_fail = 0;
    int          stat_mode = 0;
    int          done_cnt = 0;
    logic        we_d = 1'b1;
    logic [39:0] cmdq[$];
    logic [1:0]  stat;

    always #5 clk = ~clk;

    nor_block_lock_engine_if #(.ADDR_W(24)) bus ();

    nor_block_lock_engine dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .bus    (bus),
        .DATA   (DATA)
    );

    function automatic int blk_of(input logic [23:0] a);
        if (a < 24'h010000) return int'(a >> 14);
        return 4 + int'((a - 24'h010000) >> 16);
    endfunction

    function automatic logic [23:0] bbase(input int i);
        if (i < 4) return 24'(i * 'h4000);
        return 24'('h010000 + (i - 4) * 'h010000);
    endfunction

    // Flash model: status read-back, optionally failing blocks 6 and 9.
    always_comb begin
        stat = 2'b11;
        if (stat_mode == 1) begin
            stat = ((blk_of(bus.ADDR) == 6) || (blk_of(bus.ADDR) == 9)) ? 2'b01 : 2'b00;
        end
    end
    assign DATA = (!bus.CE && !bus.OE) ? {14'd0, stat} : 16'hzzzz;

    always @(negedge clk) begin
        if (!bus.WE && we_d) cmdq.push_back({bus.ADDR, DATA});
        we_d = bus.WE;
        if (bus.DONE) done_cnt++;
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sweep(input string tag, input logic [1:0] m, input logic v,
                         input bit poke, input int exp_lat);
        int lat;
        int d0;
        d0 = done_cnt;
        bus.MODE   = m;
        bus.VERIFY = v;
        bus.START  = 1'b1;
        @(negedge clk);
        bus.START  = 1'b0;
        lat = 1;
        chk({tag, "_first"}, {bus.CE, bus.WE, bus.ADDR}, 40'h0);
        while (!bus.DONE && lat < 20000) begin
            if (poke && (lat % 97 == 5)) begin
                bus.START = 1'b1;
                bus.MODE  = ~bus.MODE;
            end else begin
                bus.START = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.START = 1'b0;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_fin"}, {bus.BUSY, bus.ADDR}, 40'h0);
        repeat (30) @(negedge clk);
        chk({tag, "_ndone"}, done_cnt - d0, 1);
    endtask

    task automatic chk_cmds(input string tag, input int b0, input logic v, input logic [15:0] code);
        int per;
        int bad;
        logic [15:0] d;
        per = v ? 4 : 2;
        bad = 0;
        chk({tag, "_ncmd"}, cmdq.size() - b0, 259 * per);
        for (int i = 0; i < 259; i++) begin
            for (int p = 0; p < per; p++) begin
                d = (p == 0) ? 16'h0060 : (p == 1) ? code : (p == 2) ? 16'h0090 : 16'h00FF;
                if ((b0 + i * per + p >= cmdq.size()) ||
                    (cmdq[b0 + i * per + p] !== {bbase(i), d})) bad++;
            end
        end
        chk({tag, "_badcmd"}, bad, 0);
        if (cmdq.size() - b0 == 259 * per) begin
            chk({tag, "_blk4"}, cmdq[b0 + 4 * per], {24'h010000, 16'h0060});
            chk({tag, "_blk5c"}, cmdq[b0 + 5 * per + 1], {24'h020000, code});
            chk({tag, "_blk258"}, cmdq[b0 + 258 * per], {24'hFF0000, 16'h0060});
        end
    endtask

    initial begin
        int n;
        int b0;
        rst_n      = 1'b0;
        bus.START  = 1'b0;
        bus.MODE   = 2'b00;
        bus.VERIFY = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {bus.CE, bus.WE, bus.OE}, 3'b111);
        chk("rst_addr", bus.ADDR, 0);
        chk("rst_flags", {bus.BUSY, bus.DONE, bus.ERR}, 3'b100);
        chk("rst_fidx", bus.FAIL_IDX, 0);

        // Power-up wait with START noise that must be dropped.
        rst_n     = 1'b1;
        bus.START = 1'b1;
        n = 0;
        while (bus.BUSY && n < 50) begin
            @(negedge clk);
            n++;
            bus.START = (n < 3);
        end
        bus.START = 1'b0;
        chk("pwait_len", n, 5);
        repeat (10) @(negedge clk);
        chk("pwait_idle", {bus.BUSY, bus.CE, bus.WE}, 3'b011);
        chk("pwait_nocmd", cmdq.size(), 0);
        chk("pwait_nodone", done_cnt, 0);

        b0 = cmdq.size();
        sweep("unl", 2'b00, 1'b0, 1'b0, 259 * 11 + 1);
        chk_cmds("unl", b0, 1'b0, 16'h00D0);

        stat_mode = 0;
        b0 = cmdq.size();
        sweep("ldv", 2'b10, 1'b1, 1'b0, 259 * 26 + 1);
        chk_cmds("ldv", b0, 1'b1, 16'h002F);
        chk("ldv_err", bus.ERR, 0);

        stat_mode = 1;
        b0 = cmdq.size();
        sweep("unv", 2'b00, 1'b1, 1'b0, 259 * 26 + 1);
        chk_cmds("unv", b0, 1'b1, 16'h00D0);
        chk("unv_err", bus.ERR, 1);
        chk("unv_fidx", bus.FAIL_IDX, 6);

        b0 = cmdq.size();
        sweep("lkp", 2'b01, 1'b0, 1'b1, 259 * 11 + 1);
        chk_cmds("lkp", b0, 1'b0, 16'h0001);
        chk("lkp_errclr", bus.ERR, 0);

        // Reset while block 10's confirm write is on the bus.
        stat_mode  = 1;
        bus.MODE   = 2'b00;
        bus.VERIFY = 1'b1;
        bus.START  = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        n = 0;
        while (!(!bus.WE && DATA == 16'h00D0 && bus.ADDR == bbase(10)) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("mrst_reach", n < 5000, 1);
        chk("mrst_err_pre", bus.ERR, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_strobes", {bus.CE, bus.WE, bus.OE}, 3'b111);
        chk("mrst_flags", {bus.BUSY, bus.DONE, bus.ERR}, 3'b100);
        chk("mrst_addr", bus.ADDR, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.BUSY && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mrst_pwait", n, 5);
        b0 = cmdq.size();
        sweep("rsw", 2'b00, 1'b0, 1'b0, 259 * 11 + 1);
        chk_cmds("rsw", b0, 1'b0, 16'h00D0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
